// File: rtl/inner_ebi_ctrl_if.sv
// Signal bundle between inner_ebi_ctrl (slave) and its host/transceiver environment (master).
interface inner_ebi_ctrl_if;
  logic       rd_req_valid, wr_req_valid, wr_has_data;
  logic       snp_resp_valid, snp_has_data;
  logic       rd_req_ready, wr_req_ready, snp_resp_ready;
  logic [3:0] rcv_opcode_i;
  logic       trx_rcv_start, trx_send_done, trx_rcv_done;
  logic [3:0] opcode;
  logic       is_counter_reload, is_counter_ena, is_rd_rcv, is_send_mode;
  logic       rd_resp_valid, wr_ack_valid, snp_req_valid;
  logic       timeout_err, proto_err, busy;

  modport slave (
    input  rd_req_valid, wr_req_valid, wr_has_data, snp_resp_valid, snp_has_data,
    input  rcv_opcode_i, trx_rcv_start, trx_send_done, trx_rcv_done,
    output rd_req_ready, wr_req_ready, snp_resp_ready, opcode,
    output is_counter_reload, is_counter_ena, is_rd_rcv, is_send_mode,
    output rd_resp_valid, wr_ack_valid, snp_req_valid, timeout_err, proto_err, busy
  );

  modport master (
    output rd_req_valid, wr_req_valid, wr_has_data, snp_resp_valid, snp_has_data,
    output rcv_opcode_i, trx_rcv_start, trx_send_done, trx_rcv_done,
    input  rd_req_ready, wr_req_ready, snp_resp_ready, opcode,
    input  is_counter_reload, is_counter_ena, is_rd_rcv, is_send_mode,
    input  rd_resp_valid, wr_ack_valid, snp_req_valid, timeout_err, proto_err, busy
  );
endinterface

// File: rtl/inner_ebi_ctrl.sv
// EBI link controller: arbitrates host requests onto the transceiver, waits for and
// validates responses, and receives unsolicited snoop requests.
module inner_ebi_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  inner_ebi_ctrl_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_DR        = 4'h0,
    OP_DW1       = 4'h1,
    OP_DW2       = 4'h2,
    OP_SNP_RESP1 = 4'h3,
    OP_SNP_RESP2 = 4'h4,
    OP_IDLE      = 4'h5,
    OP_SNP_REQ   = 4'h6,
    OP_RD_RESP   = 4'h7,
    OP_ACK       = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_RESP, S_RCV_HDR, S_RCV, S_RCV_LAST
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state, state_nxt;
  logic [3:0] op_q, op_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       solicited, solicited_nxt;
  logic       rx_snp, rx_snp_nxt;
  logic       cpl_pend, cpl_pend_nxt;
  logic       armed;

  logic [3:0] req_op;
  logic       req_any, idle_live, take_rcv, take_req;
  logic       hdr_rd_ok, hdr_snp_ok, hdr_ack_ok, timeout_hit;

  // IDLE only arbitrates once out of the post-reset cycle and after any completion pulse.
  always_comb begin
    req_any = bus.snp_resp_valid | bus.wr_req_valid | bus.rd_req_valid;
    if (bus.snp_resp_valid)    req_op = bus.snp_has_data ? OP_SNP_RESP1 : OP_SNP_RESP2;
    else if (bus.wr_req_valid) req_op = bus.wr_has_data ? OP_DW1 : OP_DW2;
    else                       req_op = OP_DR;
    idle_live   = (state == S_IDLE) && armed && !cpl_pend;
    take_rcv    = idle_live && bus.trx_rcv_start;
    take_req    = idle_live && !bus.trx_rcv_start && req_any;
    hdr_rd_ok   = solicited && (op_q == OP_DR) && (bus.rcv_opcode_i == OP_RD_RESP);
    hdr_snp_ok  = !solicited && (bus.rcv_opcode_i == OP_SNP_REQ);
    hdr_ack_ok  = solicited && ((op_q == OP_DW1) || (op_q == OP_DW2)) &&
                  (bus.rcv_opcode_i == OP_ACK);
    timeout_hit = (wait_cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      op_q      <= OP_IDLE;
      wait_cnt  <= '0;
      solicited <= 1'b0;
      rx_snp    <= 1'b0;
      cpl_pend  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      wait_cnt  <= wait_cnt_nxt;
      solicited <= solicited_nxt;
      rx_snp    <= rx_snp_nxt;
      cpl_pend  <= cpl_pend_nxt;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    wait_cnt_nxt  = wait_cnt;
    solicited_nxt = solicited;
    rx_snp_nxt    = rx_snp;
    cpl_pend_nxt  = cpl_pend;
    unique case (state)
      S_IDLE: begin
        if (cpl_pend) begin
          cpl_pend_nxt = 1'b0;
        end else if (take_rcv) begin
          state_nxt     = S_RCV_HDR;
          solicited_nxt = 1'b0;
        end else if (take_req) begin
          state_nxt = S_LOAD;
          op_nxt    = req_op;
        end
      end
      S_LOAD: state_nxt = S_SEND;
      S_SEND: begin
        if (bus.trx_send_done) begin
          if ((op_q == OP_SNP_RESP1) || (op_q == OP_SNP_RESP2)) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt    = S_WAIT_RESP;
            wait_cnt_nxt = '0;
          end
        end
      end
      S_WAIT_RESP: begin
        if (bus.trx_rcv_start) begin
          state_nxt     = S_RCV_HDR;
          solicited_nxt = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_RCV_HDR: begin
        if (hdr_rd_ok || hdr_snp_ok) begin
          state_nxt  = S_RCV;
          rx_snp_nxt = hdr_snp_ok;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RCV: if (bus.trx_rcv_done) state_nxt = S_RCV_LAST;
      S_RCV_LAST: begin
        state_nxt    = S_IDLE;
        cpl_pend_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rd_req_ready      = 1'b0;
    bus.wr_req_ready      = 1'b0;
    bus.snp_resp_ready    = 1'b0;
    bus.opcode            = OP_IDLE;
    bus.is_counter_reload = 1'b0;
    bus.is_counter_ena    = 1'b0;
    bus.is_rd_rcv         = 1'b0;
    bus.is_send_mode      = 1'b0;
    bus.rd_resp_valid     = 1'b0;
    bus.wr_ack_valid      = 1'b0;
    bus.snp_req_valid     = 1'b0;
    bus.timeout_err       = 1'b0;
    bus.proto_err         = 1'b0;
    bus.busy              = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        bus.snp_resp_ready = take_req && bus.snp_resp_valid;
        bus.wr_req_ready   = take_req && !bus.snp_resp_valid && bus.wr_req_valid;
        bus.rd_req_ready   = take_req && !bus.snp_resp_valid && !bus.wr_req_valid;
        bus.rd_resp_valid  = cpl_pend && !rx_snp;
        bus.snp_req_valid  = cpl_pend && rx_snp;
      end
      S_LOAD: begin
        bus.is_counter_reload = 1'b1;
        bus.opcode            = op_q;
      end
      S_SEND: begin
        bus.is_send_mode   = 1'b1;
        bus.is_counter_ena = 1'b1;
        bus.opcode         = op_q;
      end
      S_WAIT_RESP: bus.timeout_err = !bus.trx_rcv_start && timeout_hit;
      S_RCV_HDR: begin
        bus.is_counter_reload = 1'b1;
        bus.wr_ack_valid      = hdr_ack_ok;
        bus.proto_err         = !(hdr_rd_ok || hdr_snp_ok || hdr_ack_ok);
      end
      S_RCV: begin
        bus.is_counter_ena = 1'b1;
        bus.is_rd_rcv      = 1'b1;
      end
      S_RCV_LAST: bus.is_rd_rcv = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inner_ebi_ctrl.sv
// Directed bench: scenarios are laid out as per-cycle input/expected-output tables
// built from transaction-level rules, then replayed against the controller.
module tb_inner_ebi_ctrl;

  localparam int TO   = 255;
  localparam int NCYC = 600;

  typedef struct packed {
    logic rstn, rd, wr, wr_data, snp, snp_data, rcv_start, send_done, rcv_done;
    logic [3:0] rcv_op;
  } in_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic reload, ena, rd_rcv, send_mode, rd_ready, wr_ready, snp_ready;
    logic rd_resp, wr_ack, snp_req, timeout, proto, busy;
  } out_t;

  in_t  stim [NCYC];
  out_t exp  [NCYC];
  logic [3:0] dut_op [NCYC];
  logic       dut_busy [NCYC];

  int checks = 0;
  int errors = 0;
  int first_rd_resp = -1, first_wr_ack = -1, first_proto = -1;
  int first_snp_req = -1, first_timeout = -1, n_timeout = 0;

  logic clk = 1'b1;
  logic rstn;
  always #5 clk = ~clk;

  inner_ebi_ctrl_if bus ();
  inner_ebi_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  // Request priority: snoop response, then write, then read.
  function automatic logic [3:0] pick(input in_t s);
    if (s.snp) return s.snp_data ? 4'd3 : 4'd4;
    if (s.wr)  return s.wr_data ? 4'd1 : 4'd2;
    return 4'd0;
  endfunction

  task automatic hold(input int a, input int b, input int sel, input logic dat);
    for (int c = a; c <= b; c++) begin
      case (sel)
        0: stim[c].rd = 1'b1;
        1: begin stim[c].wr = 1'b1; stim[c].wr_data = dat; end
        default: begin stim[c].snp = 1'b1; stim[c].snp_data = dat; end
      endcase
    end
  endtask

  // h = header cycle; ctx = opcode that was sent, or -1 for unsolicited traffic.
  task automatic receive(input int h, input int ctx, input logic [3:0] hdr,
                         input int r_len, output int nxt);
    stim[h].rcv_op = hdr;
    exp[h].reload = 1'b1; exp[h].busy = 1'b1;
    if ((ctx < 0 && hdr == 4'h6) || (ctx == 0 && hdr == 4'h7)) begin
      for (int c = h + 1; c <= h + r_len; c++) begin
        exp[c].ena = 1'b1; exp[c].rd_rcv = 1'b1; exp[c].busy = 1'b1;
      end
      stim[h + r_len].rcv_done = 1'b1;
      exp[h + r_len + 1].rd_rcv = 1'b1; exp[h + r_len + 1].busy = 1'b1;
      if (hdr == 4'h6) exp[h + r_len + 2].snp_req = 1'b1;
      else             exp[h + r_len + 2].rd_resp = 1'b1;
      nxt = h + r_len + 3;
    end else if ((ctx == 1 || ctx == 2) && hdr == 4'hF) begin
      exp[h].wr_ack = 1'b1; nxt = h + 1;
    end else begin
      exp[h].proto = 1'b1; nxt = h + 1;
    end
  endtask

  // t = IDLE cycle where the pending request is accepted; w_len = 0 means no response ever.
  task automatic host(input int t, input int s_len, input int w_len, input logic [3:0] hdr,
                      input int r_len, output int nxt);
    logic [3:0] op;
    int w0;
    op = pick(stim[t]);
    case (op)
      4'd0:       exp[t].rd_ready = 1'b1;
      4'd1, 4'd2: exp[t].wr_ready = 1'b1;
      default:    exp[t].snp_ready = 1'b1;
    endcase
    exp[t + 1].reload = 1'b1; exp[t + 1].opcode = op; exp[t + 1].busy = 1'b1;
    for (int c = t + 2; c <= t + 1 + s_len; c++) begin
      exp[c].send_mode = 1'b1; exp[c].ena = 1'b1; exp[c].opcode = op; exp[c].busy = 1'b1;
    end
    stim[t + 1 + s_len].send_done = 1'b1;
    w0 = t + 2 + s_len;
    if (op == 4'd3 || op == 4'd4) begin
      nxt = w0;
    end else if (w_len == 0 || w_len > TO) begin
      for (int c = w0; c < w0 + TO; c++) exp[c].busy = 1'b1;
      exp[w0 + TO - 1].timeout = 1'b1;
      nxt = w0 + TO;
    end else begin
      for (int c = w0; c < w0 + w_len; c++) exp[c].busy = 1'b1;
      stim[w0 + w_len - 1].rcv_start = 1'b1;
      receive(w0 + w_len, int'(op), hdr, r_len, nxt);
    end
  endtask

  task automatic apply(input in_t s);
    rstn               = s.rstn;
    bus.rd_req_valid   = s.rd;
    bus.wr_req_valid   = s.wr;
    bus.wr_has_data    = s.wr_data;
    bus.snp_resp_valid = s.snp;
    bus.snp_has_data   = s.snp_data;
    bus.trx_rcv_start  = s.rcv_start;
    bus.trx_send_done  = s.send_done;
    bus.trx_rcv_done   = s.rcv_done;
    bus.rcv_opcode_i   = s.rcv_op;
  endtask

  task automatic cmp(input int c, input string nm, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, want);
    end
  endtask

  task automatic check_cycle(input int c);
    out_t e;
    e = exp[c];
    cmp(c, "opcode", bus.opcode, e.opcode);
    cmp(c, "is_counter_reload", {3'b0, bus.is_counter_reload}, {3'b0, e.reload});
    cmp(c, "is_counter_ena", {3'b0, bus.is_counter_ena}, {3'b0, e.ena});
    cmp(c, "is_rd_rcv", {3'b0, bus.is_rd_rcv}, {3'b0, e.rd_rcv});
    cmp(c, "is_send_mode", {3'b0, bus.is_send_mode}, {3'b0, e.send_mode});
    cmp(c, "rd_req_ready", {3'b0, bus.rd_req_ready}, {3'b0, e.rd_ready});
    cmp(c, "wr_req_ready", {3'b0, bus.wr_req_ready}, {3'b0, e.wr_ready});
    cmp(c, "snp_resp_ready", {3'b0, bus.snp_resp_ready}, {3'b0, e.snp_ready});
    cmp(c, "rd_resp_valid", {3'b0, bus.rd_resp_valid}, {3'b0, e.rd_resp});
    cmp(c, "wr_ack_valid", {3'b0, bus.wr_ack_valid}, {3'b0, e.wr_ack});
    cmp(c, "snp_req_valid", {3'b0, bus.snp_req_valid}, {3'b0, e.snp_req});
    cmp(c, "timeout_err", {3'b0, bus.timeout_err}, {3'b0, e.timeout});
    cmp(c, "proto_err", {3'b0, bus.proto_err}, {3'b0, e.proto});
    cmp(c, "busy", {3'b0, bus.busy}, {3'b0, e.busy});
    cmp(c, "send_and_rcv_exclusive", {3'b0, bus.is_send_mode & bus.is_rd_rcv}, 4'd0);
    dut_op[c]   = bus.opcode;
    dut_busy[c] = bus.busy;
    if (bus.rd_resp_valid === 1'b1 && first_rd_resp < 0) first_rd_resp = c;
    if (bus.wr_ack_valid  === 1'b1 && first_wr_ack  < 0) first_wr_ack  = c;
    if (bus.proto_err     === 1'b1 && first_proto   < 0) first_proto   = c;
    if (bus.snp_req_valid === 1'b1 && first_snp_req < 0) first_snp_req = c;
    if (bus.timeout_err   === 1'b1) begin
      n_timeout++;
      if (first_timeout < 0) first_timeout = c;
    end
  endtask

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  initial begin
    int n;
    for (int c = 0; c < NCYC; c++) begin
      stim[c] = '0; stim[c].rstn = 1'b1; stim[c].rcv_op = 4'h5;
      exp[c]  = '0; exp[c].opcode = 4'h5;
      dut_op[c] = 4'h0; dut_busy[c] = 1'b1;
    end
    stim[0].rstn = 1'b0;
    stim[1].rstn = 1'b0;

    // Read request raised in the first post-reset cycle; accepted one cycle later.
    hold(2, 3, 0, 1'b0);
    host(3, 3, 4, 4'h7, 2, n);
    // Simultaneous write (no data) and snoop response (no data).
    hold(18, 18, 2, 1'b0);
    hold(18, 22, 1, 1'b0);
    host(18, 2, 0, 4'h0, 0, n);
    host(22, 1, 2, 4'hF, 0, n);
    // Read answered with ACK.
    hold(29, 29, 0, 1'b0);
    host(29, 1, 1, 4'hF, 0, n);
    // Incoming snoop request wins over a pending read.
    hold(35, 40, 0, 1'b0);
    stim[35].rcv_start = 1'b1;
    receive(36, -1, 4'h6, 1, n);
    host(40, 1, 1, 4'h7, 1, n);
    // Snoop response with data.
    hold(49, 49, 2, 1'b1);
    host(49, 1, 0, 4'h0, 0, n);
    // Write with data answered by RD_RESP.
    hold(53, 53, 1, 1'b1);
    host(53, 1, 3, 4'h7, 0, n);
    // Unsolicited RD_RESP.
    stim[61].rcv_start = 1'b1;
    receive(62, -1, 4'h7, 0, n);
    // Reset in the middle of SEND.
    hold(64, 64, 0, 1'b0);
    exp[64].rd_ready = 1'b1;
    exp[65].reload = 1'b1; exp[65].opcode = 4'h0; exp[65].busy = 1'b1;
    for (int c = 66; c <= 67; c++) begin
      exp[c].send_mode = 1'b1; exp[c].ena = 1'b1; exp[c].opcode = 4'h0; exp[c].busy = 1'b1;
    end
    stim[67].rstn = 1'b0;
    // Read that never gets a response.
    hold(68, 69, 0, 1'b0);
    host(69, 1, 0, 4'h0, 0, n);
    // Response start coincides with the last permitted wait cycle.
    hold(328, 328, 0, 1'b0);
    host(328, 1, TO, 4'h7, 1, n);

    apply(stim[0]);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c > 0) check_cycle(c);
      @(posedge clk);
      #1;
      if (c + 1 < NCYC) apply(stim[c + 1]);
    end

    lit("first_rd_resp_cycle", first_rd_resp, 16);
    lit("first_wr_ack_cycle", first_wr_ack, 27);
    lit("first_proto_cycle", first_proto, 33);
    lit("first_snp_req_cycle", first_snp_req, 39);
    lit("first_timeout_cycle", first_timeout, 326);
    lit("timeout_count", n_timeout, 1);
    lit("dr_opcode_c5", int'(dut_op[5]), 0);
    lit("snp_resp2_opcode_c19", int'(dut_op[19]), 4);
    lit("dw2_opcode_c23", int'(dut_op[23]), 2);
    lit("snp_resp1_opcode_c50", int'(dut_op[50]), 3);
    lit("busy_after_reset_c68", int'(dut_busy[68]), 0);
    lit("busy_after_timeout_c327", int'(dut_busy[327]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
